// File: rtl/core_system_dma_master.sv
// core_system_dma_master
// AHB-Lite bus master executing one descriptor per start: a run of
// pipelined 32-bit transfers from a start address. Reads land in a small
// FIFO that drains to a valid/ready stream. Write data is pulled from a
// valid/ready stream, one word per accepted write address.
//
// Ports:
//   HCLK, HRESET           clock, synchronous active-high reset
//   start, cfg_*           descriptor strobe and fields (taken while idle)
//   busy, done, error      status: in progress, completion pulse, sticky error
//   HADDR..HWDATA          AHB-Lite master request outputs
//   HREADY, HRDATA, HRESP  AHB-Lite slave response inputs
//   rd_data/valid/ready    read-data stream out of the FIFO
//   wr_data/valid/ready    write-data stream in
module core_system_dma_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic [31:0]      cfg_addr,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_write,
  input  logic             cfg_incr,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      HADDR,
  output logic [2:0]       HBURST,
  output logic [2:0]       HSIZE,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic [31:0]      HRDATA,
  input  logic             HRESP,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LAST = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;      // address of the next beat to issue
  logic [LEN_W-1:0] left_q, left_d;      // beats still to issue
  logic             write_q, write_d;
  logic             incr_q, incr_d;
  logic             first_q, first_d;    // next beat is the first of the descriptor
  logic             dph_q, dph_d;        // a beat is in its data phase
  logic             err_q, err_d;
  logic [31:0]      hwdata_q, hwdata_d;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;

  logic             err_now;
  logic             rd_out;
  logic [CW:0]      credit_sum;
  logic             issue_ok;
  logic             seq_ok;
  logic             push;
  logic             pop;
  logic [1:0]       htrans;
  logic             wr_take;

  // An ERROR response shows up first as HRESP=1 with HREADY=0.
  assign err_now    = dph_q && HRESP && !HREADY;
  // A read in its data phase already owns a FIFO slot.
  assign rd_out     = dph_q && !write_q;
  assign credit_sum = {1'b0, cnt_q} + {{CW{1'b0}}, rd_out};
  assign issue_ok   = write_q ? wr_valid : (credit_sum < (CW+1)'(FIFO_DEPTH));
  // Continuation of an INCR burst, unless the beat starts a new 1KB page.
  assign seq_ok     = incr_q && !first_q && (addr_q[9:0] != 10'd0);
  assign push       = dph_q && !write_q && HREADY && !HRESP;
  assign pop        = (cnt_q != '0) && rd_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    left_d   = left_q;
    write_d  = write_q;
    incr_d   = incr_q;
    first_d  = first_q;
    err_d    = err_q;
    hwdata_d = hwdata_q;
    dph_d    = HREADY ? 1'b0 : dph_q;
    htrans   = TR_IDLE;
    wr_take  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = {cfg_addr[31:2], 2'b00};
          left_d  = cfg_len;
          write_d = cfg_write;
          incr_d  = cfg_incr;
          first_d = 1'b1;
          err_d   = 1'b0;
          state_d = (cfg_len == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        if (err_now) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (issue_ok) begin
          htrans = seq_ok ? TR_SEQ : TR_NONSEQ;
          if (HREADY) begin
            addr_d  = addr_q + 32'd4;
            left_d  = left_q - LEN_W'(1);
            first_d = 1'b0;
            dph_d   = 1'b1;
            if (write_q) begin
              wr_take  = 1'b1;
              hwdata_d = wr_data;
            end
            if (left_q == LEN_W'(1)) state_d = S_LAST;
          end
        end else begin
          // BUSY is only legal inside a burst that will continue with SEQ.
          htrans = seq_ok ? TR_BUSY : TR_IDLE;
        end
      end
      S_LAST: begin
        if (err_now) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (!dph_q || HREADY) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        if (HREADY) state_d = S_DONE;
      end
      default: begin
        state_d  = S_IDLE;
        addr_d   = '0;
        left_d   = '0;
        write_d  = 1'b0;
        incr_d   = 1'b0;
        first_d  = 1'b0;
        dph_d    = 1'b0;
        err_d    = 1'b0;
        hwdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      left_q   <= '0;
      write_q  <= 1'b0;
      incr_q   <= 1'b0;
      first_q  <= 1'b0;
      dph_q    <= 1'b0;
      err_q    <= 1'b0;
      hwdata_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      left_q   <= left_d;
      write_q  <= write_d;
      incr_q   <= incr_d;
      first_q  <= first_d;
      dph_q    <= dph_d;
      err_q    <= err_d;
      hwdata_q <= hwdata_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wptr_q] <= HRDATA;
  end

  assign busy     = (state_q == S_ADDR) || (state_q == S_LAST) || (state_q == S_ERR);
  assign done     = (state_q == S_DONE);
  assign error    = err_q;
  assign HADDR    = addr_q;
  assign HBURST   = {2'b00, incr_q};
  assign HSIZE    = 3'b010;
  assign HTRANS   = htrans;
  assign HWRITE   = write_q;
  assign HWDATA   = hwdata_q;
  assign rd_data  = mem[rptr_q];
  assign rd_valid = (cnt_q != '0);
  assign wr_ready = wr_take;

endmodule

// File: tb/tb_core_system_dma_master.sv
module tb_core_system_dma_master;

  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 16;
  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

  logic             HCLK, HRESET, start, cfg_write, cfg_incr;
  logic [31:0]      cfg_addr;
  logic [LEN_W-1:0] cfg_len;
  logic             busy, done, error;
  logic [31:0]      HADDR, HWDATA, HRDATA;
  logic [2:0]       HBURST, HSIZE;
  logic [1:0]       HTRANS;
  logic             HWRITE, HREADY, HRESP;
  logic [31:0]      rd_data, wr_data;
  logic             rd_valid, rd_ready, wr_valid, wr_ready;

  core_system_dma_master #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .cfg_addr(cfg_addr),
    .cfg_len(cfg_len), .cfg_write(cfg_write), .cfg_incr(cfg_incr),
    .busy(busy), .done(done), .error(error), .HADDR(HADDR), .HBURST(HBURST),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: descriptor progress counted in beats, the slave's data
  // phase, the FIFO as a queue of expected words, accepted write words.
  bit          m_in_desc, m_write, m_incr, m_errored, m_done_exp, m_error_exp;
  logic [31:0] m_base;
  int          m_len, m_issued, m_err_beat, err_stage;
  bit          dph_valid, dph_write;
  int          dph_idx;
  logic [31:0] dph_addr;
  logic [31:0] rdq[$];
  logic [31:0] wexp[$];
  int          p_wait, p_rdy, p_wv, rd_hold, obs_acc;
  bit          bp_check;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One bus cycle: drive inputs at negedge, check settled outputs, advance model.
  task automatic step();
    logic [1:0]  exp_trans;
    logic [31:0] next_addr;
    bit err_now, s_addr, cond, exp_acc, pop, dcomp, next_done, start_acc, wtaken;
    if (dph_valid && m_in_desc && dph_idx == m_err_beat) begin
      HREADY = (err_stage != 0);
      HRESP  = 1'b1;
    end else if (dph_valid) begin
      HREADY = ($urandom_range(99) >= p_wait);
      HRESP  = 1'b0;
    end else begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
    end
    HRDATA   = (dph_valid && !dph_write && HREADY) ? mem_word(dph_addr) : $urandom;
    rd_ready = (rd_hold > 0) ? 1'b0 : ($urandom_range(99) < p_rdy);
    if (!wr_valid && $urandom_range(99) < p_wv) begin
      wr_valid = 1'b1;
      wr_data  = $urandom;
    end
    #1;
    start_acc = start && !m_in_desc && !m_done_exp;
    err_now   = dph_valid && HRESP && !HREADY;
    s_addr    = m_in_desc && !m_errored && (m_issued < m_len);
    next_addr = m_base + (32'(m_issued) << 2);
    cond      = m_write ? wr_valid
                        : ((rdq.size() + ((dph_valid && !dph_write) ? 1 : 0)) < FIFO_DEPTH);
    if (!s_addr || err_now) exp_trans = T_IDLE;
    else if (cond) exp_trans = (m_issued == 0 || !m_incr || next_addr[9:0] == 10'd0) ? T_NONSEQ : T_SEQ;
    else exp_trans = (m_incr && m_issued != 0 && next_addr[9:0] != 10'd0) ? T_BUSY : T_IDLE;
    check_eq("htrans", HTRANS, exp_trans);
    if (exp_trans != T_IDLE) begin
      check_eq("haddr", HADDR, next_addr);
      check_eq("hwrite", HWRITE, m_write);
      check_eq("hburst", HBURST, {2'b00, m_incr});
    end
    exp_acc = exp_trans[1] && HREADY;
    check_eq("wr_ready", wr_ready, exp_acc && m_write);
    check_eq("done", done, m_done_exp);
    check_eq("busy", busy, m_in_desc);
    check_eq("error", error, m_error_exp);
    check_eq("rd_valid", rd_valid, rdq.size() != 0);
    check_eq("hsize", HSIZE, 3'b010);
    if (HTRANS[1] && HREADY) obs_acc++;
    if (bp_check && rd_hold == 1) begin
      check_eq("bp_issued", obs_acc, 4);
      check_eq("bp_htrans", HTRANS, T_BUSY);
      check_eq("bp_haddr", HADDR, 32'h110);
    end
    pop = (rdq.size() != 0) && rd_ready;
    if (pop) check_eq("rd_data", rd_data, rdq[0]);
    dcomp = dph_valid && HREADY;
    if (dcomp && dph_write) begin
      check_eq("hwdata_avail", wexp.size() != 0, 1);
      if (wexp.size() != 0) check_eq("hwdata", HWDATA, wexp.pop_front());
    end
    next_done = (start_acc && cfg_len == '0) ||
                (m_in_desc && !m_errored && m_issued == m_len && dcomp) ||
                (m_errored && HREADY);
    wtaken = exp_acc && m_write;
    if (wtaken) wexp.push_back(wr_data);
    @(posedge HCLK);
    if (pop) void'(rdq.pop_front());
    if (dcomp && !dph_write && !HRESP) rdq.push_back(mem_word(dph_addr));
    check_eq("fifo_bound", rdq.size() <= FIFO_DEPTH, 1);
    if (HREADY) begin
      dph_valid = exp_acc;
      if (exp_acc) begin
        dph_addr  = next_addr;
        dph_write = m_write;
        dph_idx   = m_issued;
      end
    end
    if (exp_acc) m_issued++;
    if (err_now) begin
      m_errored   = 1'b1;
      m_error_exp = 1'b1;
      err_stage   = 1;
    end
    if (next_done) begin
      m_in_desc = 1'b0;
      m_errored = 1'b0;
      err_stage = 0;
    end
    m_done_exp = next_done;
    if (start_acc) begin
      m_base      = {cfg_addr[31:2], 2'b00};
      m_len       = int'(cfg_len);
      m_write     = cfg_write;
      m_incr      = cfg_incr;
      m_issued    = 0;
      m_in_desc   = (cfg_len != '0);
      m_error_exp = 1'b0;
    end
    if (rd_hold > 0) rd_hold--;
    @(negedge HCLK);
    if (wtaken) wr_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    HRESET = 1'b1; start = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    rd_ready = 1'b0; wr_valid = 1'b0;
    repeat (cycles) @(posedge HCLK);
    #1;
    check_eq("rst_htrans", HTRANS, T_IDLE);
    check_eq("rst_haddr", HADDR, 0);
    check_eq("rst_hburst", HBURST, 0);
    check_eq("rst_hwrite", HWRITE, 0);
    check_eq("rst_hwdata", HWDATA, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    m_in_desc = 0; m_errored = 0; m_done_exp = 0; m_error_exp = 0; err_stage = 0;
    m_issued = 0; m_len = 0; m_write = 0; m_incr = 0; m_base = '0;
    dph_valid = 0; rdq.delete(); wexp.delete(); rd_hold = 0;
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic run_desc(input logic [31:0] a, input int len, input bit w, input bit inc, input int eb);
    bit fin;
    fin = 1'b0;
    cfg_addr = a; cfg_len = LEN_W'(len); cfg_write = w; cfg_incr = inc;
    m_err_beat = eb;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      fin = m_done_exp;
      step();
    end
    check_eq("desc_completed", fin, 1);
  endtask

  initial begin
    int n;
    HRESET = 1'b1; start = 1'b0; cfg_addr = '0; cfg_len = '0; cfg_write = 1'b0;
    cfg_incr = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0; rd_ready = 1'b0;
    wr_valid = 1'b0; wr_data = '0;
    p_wait = 0; p_rdy = 100; p_wv = 100; rd_hold = 0; bp_check = 0; obs_acc = 0;
    m_err_beat = -1;
    @(negedge HCLK);
    do_reset(2);

    // Read INCR, no stalls
    run_desc(32'h100, 4, 1'b0, 1'b1, -1);
    repeat (4) step();

    // Read with consumer stalled: credit limit then BUSY
    rd_hold = 12; bp_check = 1; obs_acc = 0;
    run_desc(32'h100, 8, 1'b0, 1'b1, -1);
    bp_check = 0;
    repeat (4) step();

    // Write SINGLE with a gappy producer
    p_wv = 50;
    run_desc(32'h2000, 3, 1'b1, 1'b0, -1);
    p_wv = 100;

    // INCR across a 1KB page
    run_desc(32'h3F8, 4, 1'b0, 1'b1, -1);
    repeat (4) step();

    // Error on the third beat with wait states, FIFO held
    p_wait = 40; rd_hold = 400;
    run_desc(32'h500, 6, 1'b0, 1'b1, 2);
    check_eq("err_sticky", error, 1);
    rd_hold = 0; p_rdy = 100; p_wait = 0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (rd_valid) n++;
      step();
    end
    check_eq("err_fifo_words", n, 2);

    // Zero-length descriptor
    run_desc(32'h40, 0, 1'b1, 1'b1, -1);

    // Reset in the middle of a burst
    cfg_addr = 32'h800; cfg_len = LEN_W'(8); cfg_write = 1'b0; cfg_incr = 1'b1;
    m_err_beat = -1; rd_hold = 10;
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    do_reset(1);

    // Randomized descriptors
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      int len, eb;
      a = $urandom;
      case ($urandom_range(3))
        0: a = 32'h0000_03E0 + 32'($urandom_range(31));
        1: a = 32'hFFFF_FFE8 + 32'($urandom_range(7));
        default: ;
      endcase
      len = $urandom_range(0, 12);
      eb  = (len > 0 && $urandom_range(4) == 0) ? $urandom_range(len - 1) : -1;
      p_wait = $urandom_range(0, 40);
      p_rdy  = $urandom_range(30, 100);
      p_wv   = $urandom_range(30, 100);
      run_desc(a, len, 1'($urandom_range(1)), 1'($urandom_range(1)), eb);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
